// File: rtl/keypad_event_scanner.sv
// -----------------------------------------------------------------------------
// keypad_event_scanner
//
// Front end for the vending_machine controller. It scans a 4x4 matrix keypad
// one column at a time and resolves each full scan frame to NONE, a single key,
// or MULTI. Frame results are debounced across frames, and the block emits one
// key_valid pulse for each physical press.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-low reset
//   row[3:0]   keypad rows, active-low (0 = key pressed in the driven column)
//   shift_col  column drive, one-cold active-low (1110 -> 1101 -> 1011 -> 0111)
//   key_code   code of the last accepted key; holds until the next one
//   key_valid  one-cycle pulse when a new press is accepted
//   key_held   high while a debounced key is stable-pressed
// -----------------------------------------------------------------------------
module keypad_event_scanner #(
  parameter int SCAN_DIV       = 50000,  // dwell cycles per column, >= 2
  parameter int DEBOUNCE_SCANS = 4       // identical frames to change state, >= 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] shift_col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int MW = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_DIV - 1);
  localparam logic [MW-1:0] MATCH_MAX  = MW'(DEBOUNCE_SCANS);

  // Frame classes. The saturated hit count (0, 1, 2+) is used directly as
  // the class.
  localparam logic [1:0] RES_NONE  = 2'd0;
  localparam logic [1:0] RES_KEY   = 2'd1;
  localparam logic [1:0] RES_MULTI = 2'd2;

  // present=0 means NONE. The code field is kept at 0 in that case, so a
  // plain equality compares two key states correctly.
  typedef struct packed {
    logic       present;
    logic [3:0] code;
  } key_t;

  localparam key_t KEY_NONE = '0;

  // Key map: row r is bit r and column c is bit c. The codes E/F/D carry
  // fixed meaning in the controller.
  function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  4'hF: code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  logic [CW-1:0] dwell_cnt;
  logic [1:0]    col_idx;
  logic [1:0]    acc_hits;   // saturating count of low intersections so far
  logic [3:0]    acc_code;   // code of the single hit seen so far, if any
  key_t          cand;
  key_t          stable;
  logic [MW-1:0] match_cnt;

  logic [3:0]    col_low;
  logic [2:0]    col_sum;
  logic [1:0]    col_hits;
  logic [1:0]    hit_row;
  logic [2:0]    tot_sum;
  logic [1:0]    frame_hits;
  logic [3:0]    frame_code;
  key_t          result;
  key_t          next_cand;
  logic [MW-1:0] next_match;
  logic          promote;

  // Evaluate the column currently being sampled, folded into the frame so far.
  always_comb begin
    // NOTE: each always_comb output is assigned a default first, so every path
    // drives it and no latch is inferred.
    col_low = ~row;
    col_sum = 3'(col_low[0]) + 3'(col_low[1]) + 3'(col_low[2]) + 3'(col_low[3]);
    col_hits = (col_sum >= 3'd2) ? RES_MULTI : col_sum[1:0];

    hit_row = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (col_low[r]) hit_row = 2'(r);
    end

    tot_sum    = {1'b0, acc_hits} + {1'b0, col_hits};
    frame_hits = (tot_sum >= 3'd2) ? RES_MULTI : tot_sum[1:0];
    frame_code = (col_hits == RES_KEY) ? key_lookup(hit_row, col_idx) : acc_code;
  end

  // Debounce next state. This result is committed only at frame end.
  always_comb begin
    result = KEY_NONE;
    if (frame_hits == RES_KEY) result = '{present: 1'b1, code: frame_code};

    next_cand  = cand;
    next_match = match_cnt;
    if (frame_hits == RES_MULTI) begin
      next_match = '0;             // a chord breaks the run but keeps the candidate
    end else if (result == cand) begin
      if (match_cnt != MATCH_MAX) next_match = match_cnt + MW'(1);
    end else begin
      next_cand  = result;
      next_match = MW'(1);
    end

    promote = (next_match == MATCH_MAX) && (next_cand != stable);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dwell_cnt <= '0;
      col_idx   <= 2'd0;
      shift_col <= 4'b1110;
      acc_hits  <= RES_NONE;
      acc_code  <= 4'h0;
      cand      <= KEY_NONE;
      stable    <= KEY_NONE;
      match_cnt <= '0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only. Every read
      // in this block therefore sees the value from before the edge.
      key_valid <= 1'b0;
      if (dwell_cnt == DWELL_LAST) begin
        // The row has settled for the whole dwell. Sample it, then move to the next column.
        dwell_cnt <= '0;
        col_idx   <= col_idx + 2'd1;
        shift_col <= {shift_col[2:0], shift_col[3]};
        if (col_idx == 2'd3) begin
          acc_hits  <= RES_NONE;
          acc_code  <= 4'h0;
          cand      <= next_cand;
          match_cnt <= next_match;
          if (promote) begin
            stable   <= next_cand;
            key_held <= next_cand.present;
            if (next_cand.present) begin
              key_code <= next_cand.code;
              // Pulse only on a press from NONE. A roll between keys updates
              // the code silently.
              key_valid <= !stable.present;
            end
          end
        end else begin
          acc_hits <= frame_hits;
          acc_code <= frame_code;
        end
      end else begin
        dwell_cnt <= dwell_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_keypad_event_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_event_scanner
//
// Directed bench for keypad_event_scanner with SCAN_DIV=4 and DEBOUNCE_SCANS=2
// (a frame is 16 cycles). A keypad model drives row from shift_col and the set
// of pressed keys. Every task starts and ends on the falling edge right after a
// frame end, so a change to the pressed keys covers whole frames.
// -----------------------------------------------------------------------------
module tb_keypad_event_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 2;
  localparam int FRAME    = 4 * SCAN_DIV;

  // Bit index of a key in 'pressed' is row*4 + column.
  localparam int K_1 = 0;
  localparam int K_4 = 4;
  localparam int K_5 = 5;
  localparam int K_8 = 9;
  localparam int K_9 = 10;
  localparam int K_E = 12;
  localparam int K_F = 14;

  logic       clk;
  logic       reset;
  logic [3:0] row;
  logic [3:0] shift_col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] pressed;
  int          n_cmp;
  int          n_fail;

  // Expected key map, indexed by row*4 + column.
  logic [3:0] exp_map [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                               4'h4, 4'h5, 4'h6, 4'hB,
                               4'h7, 4'h8, 4'h9, 4'hC,
                               4'hE, 4'h0, 4'hF, 4'hD};

  keypad_event_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
    .clk       (clk),
    .reset     (reset),
    .row       (row),
    .shift_col (shift_col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad model: a pressed key pulls its row low while its column is driven.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4 + c] && !shift_col[c]) row[r] = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected finish within 2 ms");
    $fatal(1, "watchdog expired");
  end

  // Run one frame. Sample on the falling edges, and record the pulse count and
  // the code and position of the last pulse.
  task automatic run_frame(output int pulses, output logic [3:0] pcode, output int ppos);
    pulses = 0;
    pcode  = 4'h0;
    ppos   = -1;
    for (int i = 0; i < FRAME; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (key_valid === 1'b1) begin
        pulses++;
        pcode = key_code;
        ppos  = i;
      end
    end
  endtask

  task automatic test_reset;
    int         p, pos;
    logic [3:0] c, e;
    int         bad;
    reset   = 1'b0;
    pressed = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (shift_col !== 4'b1110) begin n_fail++; $display("FAIL reset_shift_col: got %b expected 1110", shift_col); end
    n_cmp++; if (key_code !== 4'h0) begin n_fail++; $display("FAIL reset_key_code: got %h expected 0", key_code); end
    n_cmp++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_key_valid: got %b expected 0", key_valid); end
    n_cmp++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL reset_key_held: got %b expected 0", key_held); end
    reset = 1'b1;
    bad = 0;
    for (int k = 1; k <= FRAME; k++) begin
      @(posedge clk);
      @(negedge clk);
      e = 4'b0001 << ((k / SCAN_DIV) % 4);
      e = ~e;
      n_cmp++; if (shift_col !== e) begin n_fail++; $display("FAIL scan_rotation cycle %0d: got %b expected %b", k, shift_col, e); end
      if (key_valid !== 1'b0 || key_held !== 1'b0 || key_code !== 4'h0) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL idle_frame1_outputs: got %0d nonzero cycles expected 0", bad); end
    for (int f = 2; f <= 10; f++) begin
      run_frame(p, c, pos);
      n_cmp++; if (p !== 0) begin n_fail++; $display("FAIL idle_pulses frame %0d: got %0d expected 0", f, p); end
      n_cmp++; if (key_held !== 1'b0 || key_code !== 4'h0) begin
        n_fail++; $display("FAIL idle_state frame %0d: got held=%b code=%h expected held=0 code=0", f, key_held, key_code);
      end
    end
  endtask

  task automatic test_single_press;
    int         p, pos;
    logic [3:0] c;
    pressed = 16'(1) << K_5;
    for (int f = 1; f <= 5; f++) begin
      run_frame(p, c, pos);
      n_cmp++; if (p !== ((f == 2) ? 1 : 0)) begin n_fail++; $display("FAIL press5_pulses frame %0d: got %0d expected %0d", f, p, (f == 2) ? 1 : 0); end
      if (f == 2) begin
        n_cmp++; if (c !== 4'h5 || pos !== FRAME - 1) begin
          n_fail++; $display("FAIL press5_event: got code=%h pos=%0d expected code=5 pos=%0d", c, pos, FRAME - 1);
        end
      end
      n_cmp++; if (key_held !== (f >= 2)) begin n_fail++; $display("FAIL press5_held frame %0d: got %b expected %b", f, key_held, f >= 2); end
    end
    pressed = '0;
    run_frame(p, c, pos);
    n_cmp++; if (key_held !== 1'b1 || key_code !== 4'h5) begin
      n_fail++; $display("FAIL release5_frame1: got held=%b code=%h expected held=1 code=5", key_held, key_code);
    end
    run_frame(p, c, pos);
    n_cmp++; if (key_held !== 1'b0 || key_code !== 4'h5 || p !== 0) begin
      n_fail++; $display("FAIL release5_frame2: got held=%b code=%h pulses=%0d expected held=0 code=5 pulses=0", key_held, key_code, p);
    end
  endtask

  task automatic test_bounce;
    int         p, pos;
    logic [3:0] c;
    logic [5:0] pat = 6'b111101;  // bit f: key F present in frame f
    for (int f = 0; f < 6; f++) begin
      pressed = pat[f] ? (16'(1) << K_F) : 16'h0;
      run_frame(p, c, pos);
      n_cmp++; if (p !== ((f == 3) ? 1 : 0)) begin n_fail++; $display("FAIL bounce_pulses frame %0d: got %0d expected %0d", f, p, (f == 3) ? 1 : 0); end
      if (f == 3) begin
        n_cmp++; if (c !== 4'hF) begin n_fail++; $display("FAIL bounce_code: got %h expected F", c); end
      end
    end
    pressed = '0;
    repeat (2) run_frame(p, c, pos);
    n_cmp++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL bounce_release_held: got %b expected 0", key_held); end
  endtask

  task automatic test_multi;
    int         p, pos, total;
    logic [3:0] c;
    pressed = (16'(1) << K_1) | (16'(1) << K_4);
    total = 0;
    for (int f = 0; f < 4; f++) begin
      run_frame(p, c, pos);
      total += p;
      n_cmp++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL multi_held frame %0d: got %b expected 0", f, key_held); end
    end
    n_cmp++; if (total !== 0) begin n_fail++; $display("FAIL multi_pulses: got %0d expected 0", total); end
    n_cmp++; if (key_code !== 4'hF) begin n_fail++; $display("FAIL multi_code_hold: got %h expected F", key_code); end
    pressed = 16'(1) << K_1;
    run_frame(p, c, pos);
    n_cmp++; if (p !== 0) begin n_fail++; $display("FAIL multi_to_1_frame1: got %0d pulses expected 0", p); end
    run_frame(p, c, pos);
    n_cmp++; if (p !== 1 || c !== 4'h1) begin n_fail++; $display("FAIL multi_to_1_event: got pulses=%0d code=%h expected pulses=1 code=1", p, c); end
    pressed = '0;
    repeat (2) run_frame(p, c, pos);
  endtask

  task automatic test_roll;
    int         p, pos, total;
    logic [3:0] c;
    pressed = 16'(1) << K_8;
    run_frame(p, c, pos);
    run_frame(p, c, pos);
    n_cmp++; if (p !== 1 || c !== 4'h8) begin n_fail++; $display("FAIL roll_press8: got pulses=%0d code=%h expected pulses=1 code=8", p, c); end
    pressed = 16'(1) << K_9;
    total = 0;
    run_frame(p, c, pos);
    total += p;
    n_cmp++; if (key_code !== 4'h8) begin n_fail++; $display("FAIL roll_code_frame1: got %h expected 8", key_code); end
    run_frame(p, c, pos);
    total += p;
    n_cmp++; if (key_code !== 4'h9 || key_held !== 1'b1) begin
      n_fail++; $display("FAIL roll_code_frame2: got code=%h held=%b expected code=9 held=1", key_code, key_held);
    end
    run_frame(p, c, pos);
    total += p;
    n_cmp++; if (total !== 0) begin n_fail++; $display("FAIL roll_pulses: got %0d expected 0", total); end
    pressed = '0;
    repeat (2) run_frame(p, c, pos);
    n_cmp++; if (key_held !== 1'b0 || key_code !== 4'h9) begin
      n_fail++; $display("FAIL roll_release: got held=%b code=%h expected held=0 code=9", key_held, key_code);
    end
    pressed = 16'(1) << K_9;
    total = 0;
    run_frame(p, c, pos);
    total += p;
    run_frame(p, c, pos);
    total += p;
    n_cmp++; if (total !== 1 || c !== 4'h9) begin n_fail++; $display("FAIL roll_repress9: got pulses=%0d code=%h expected pulses=1 code=9", total, c); end
    pressed = '0;
    repeat (2) run_frame(p, c, pos);
  endtask

  task automatic test_keymap;
    int         p, pos, total;
    logic [3:0] c, got;
    for (int i = 0; i < 16; i++) begin
      pressed = 16'(1) << i;
      total = 0;
      got = 4'h0;
      for (int f = 0; f < DEB; f++) begin
        run_frame(p, c, pos);
        total += p;
        if (p > 0) got = c;
      end
      n_cmp++; if (total !== 1 || got !== exp_map[i]) begin
        n_fail++; $display("FAIL keymap r%0d c%0d: got pulses=%0d code=%h expected pulses=1 code=%h", i / 4, i % 4, total, got, exp_map[i]);
      end
      pressed = '0;
      repeat (2) run_frame(p, c, pos);
    end
  endtask

  task automatic test_reset_mid_press;
    int         p, pos;
    logic [3:0] c;
    pressed = 16'(1) << K_E;
    run_frame(p, c, pos);
    run_frame(p, c, pos);
    n_cmp++; if (p !== 1 || c !== 4'hE) begin n_fail++; $display("FAIL resetmid_pressE: got pulses=%0d code=%h expected pulses=1 code=E", p, c); end
    run_frame(p, c, pos);
    #2;
    reset = 1'b0;
    #1;
    n_cmp++; if (key_code !== 4'h0 || key_held !== 1'b0 || key_valid !== 1'b0 || shift_col !== 4'b1110) begin
      n_fail++; $display("FAIL resetmid_async: got code=%h held=%b valid=%b col=%b expected code=0 held=0 valid=0 col=1110",
                         key_code, key_held, key_valid, shift_col);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    run_frame(p, c, pos);
    n_cmp++; if (p !== 0 || key_held !== 1'b0) begin n_fail++; $display("FAIL resetmid_frame1: got pulses=%0d held=%b expected pulses=0 held=0", p, key_held); end
    run_frame(p, c, pos);
    n_cmp++; if (p !== 1 || c !== 4'hE || pos !== FRAME - 1 || key_held !== 1'b1) begin
      n_fail++; $display("FAIL resetmid_reaccept: got pulses=%0d code=%h pos=%0d held=%b expected pulses=1 code=E pos=%0d held=1",
                         p, c, pos, key_held, FRAME - 1);
    end
    pressed = '0;
    repeat (2) run_frame(p, c, pos);
  endtask

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    pressed = '0;
    reset   = 1'b0;
    test_reset;
    test_single_press;
    test_bounce;
    test_multi;
    test_roll;
    test_keymap;
    test_reset_mid_press;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_event_scanner.md
Name: keypad_event_scanner

Overview:
- Upstream input stage for the vending_machine controller.
- Drives the 4x4 matrix keypad columns and samples the rows.
- Resolves one key per full scan frame, debounces across frames, then emits a single-cycle key event with a 4-bit code.
- Replaces level-style key_value plus separate debounce: the controller sees exactly one key_valid pulse per physical press.

Parameters:
SCAN_DIV, 50000, clock cycles each column is driven (dwell); minimum 2
DEBOUNCE_SCANS, 4, consecutive identical frames needed to change the stable state; minimum 1

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-low reset
row  input  4  keypad rows, active-low (pulled up, 0 = pressed key in the driven column)
shift_col  output  4  column drive, one-cold active-low
key_code  output  4  code of the last accepted key; holds until the next accepted key
key_valid  output  1  one-cycle pulse when a new press is accepted
key_held  output  1  high while a debounced key is stable-pressed

Behaviour:
- Reset (reset=0, async) sets the following:
  - shift_col=4'b1110, column index 0, dwell counter 0
  - frame accumulator cleared; candidate = NONE; match count 0; stable = NONE
  - key_code=4'h0, key_valid=0, key_held=0
- Column scan:
  - Dwell counter runs 0..SCAN_DIV-1.
  - On count SCAN_DIV-1, row is sampled (settled value), then the column index advances.
  - shift_col rotates 1110 -> 1101 -> 1011 -> 0111 -> 1110.
  - A frame is 4*SCAN_DIV cycles; it ends on the sample of column 3.
- Key map (row r = bit r, column c = bit c):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
  - F = next, E = confirm, D = take product; these codes are fixed for the controller.
- Frame result:
  - NONE when no row bit is low in any column.
  - KEY(x) when exactly one row/column intersection is low.
  - MULTI when two or more are low (ghosting or chording).
- Debounce, evaluated once per frame end:
  - MULTI: candidate is unchanged, match count resets to 0, stable is unchanged, no event.
  - Result equals candidate: match count increments, saturating at DEBOUNCE_SCANS.
  - Otherwise: candidate = result, match count = 1.
  - When match count reaches DEBOUNCE_SCANS and candidate != stable, stable = candidate.
- Outputs:
  - Transition NONE -> KEY(x): key_code <= x in the same cycle that key_valid=1 for exactly one cycle.
  - Transition KEY(x) -> KEY(y) without passing through NONE: stable = KEY(y), key_code <= y, no key_valid pulse. A new event requires a release first.
  - Transition KEY -> NONE: key_held falls, key_code holds, no pulse.
  - key_held = (stable != NONE), registered.
- Latency: with a clean press, key_valid occurs at the end of frame DEBOUNCE_SCANS after the first frame that saw the key. Maximum is (DEBOUNCE_SCANS+1)*4*SCAN_DIV cycles.
- A press shorter than DEBOUNCE_SCANS frames produces no event and no key_held.
- Holding a key indefinitely produces exactly one pulse (no auto-repeat).
- Reset mid-press clears everything. If the key is still held after reset, it is re-accepted as a new press after DEBOUNCE_SCANS frames.
- All outputs are registered; no combinational path from row to outputs.
- Counters are sized as clog2(SCAN_DIV) and clog2(DEBOUNCE_SCANS+1).

Test Plan:
(SCAN_DIV=4, DEBOUNCE_SCANS=2, frame = 16 cycles)
- Reset release, row=4'hF:
  - shift_col cycles 1110,1101,1011,0111 every 4 cycles.
  - key_valid, key_held, key_code all 0 for 10 frames.
- Hold key "5" (row1 low while shift_col=1101) for 5 frames:
  - exactly one key_valid pulse with key_code=4'h5, at end of the 2nd frame containing the key.
  - key_held=1 until 2 frames after release; key_code stays 5.
- Bounce: key "F" present in 1 frame, absent 1, present 1, then held 3 frames:
  - no pulse from the isolated frames.
  - one pulse with key_code=4'hF after 2 consecutive frames.
- Keys "1" and "4" together for 4 frames:
  - MULTI; no event, key_held=0.
  - Then release "4" leaving "1": pulse with key_code=4'h1 after 2 frames.
- Roll: stable "8", then directly switch to "9" for 3 frames:
  - key_code becomes 4'h9 with no key_valid.
  - After release and re-press of "9": one pulse.
- Assert reset while "E" is stable:
  - outputs return to 0 asynchronously.
  - After deassert with "E" still held: new pulse with key_code=4'hE after 2 frames.
